// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - CPU/debug arbiter for the shared single-port 128x8 data RAM
module data_ram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [6:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_lock,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [6:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_gnt,
    output logic       dbg_rvalid,
    output logic [7:0] dbg_rdata,
    output logic [6:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_en,
    input  logic [7:0] ram_q,
    output logic       lock_err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] LOCK_SAT   = 4'(LOCK_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       lock_err_q, lock_err_d;
    logic       cpu_rd_q, cpu_rd_d;
    logic       dbg_rd_q, dbg_rd_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] dbg_rdata_q, dbg_rdata_d;

    logic lock_active;
    logic force_dbg;
    logic gnt_cpu;
    logic gnt_dbg;

    always_comb begin
        lock_active = cpu_lock && (lock_cnt_q < LOCK_SAT);
        force_dbg   = dbg_req && (starve_cnt_q == STARVE_MAX);
        gnt_cpu     = 1'b0;
        gnt_dbg     = 1'b0;
        if (!rst) begin
            // An active lock shuts debug out even when the CPU is idle this cycle.
            if (lock_active) begin
                gnt_cpu = cpu_req;
            end else if (force_dbg) begin
                gnt_dbg = 1'b1;
            end else if (cpu_req) begin
                gnt_cpu = 1'b1;
            end else if (dbg_req) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_gnt = gnt_cpu;
        dbg_gnt = gnt_dbg;
        if (rst) begin
            ram_addr = 7'd0;
            ram_data = 8'd0;
        end else if (gnt_dbg) begin
            ram_addr = dbg_addr;
            ram_data = dbg_wdata;
        end else begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
        end
        ram_en = (gnt_cpu && cpu_we) || (gnt_dbg && dbg_we);

        // ram_q carries the read data during the rvalid cycle; the register holds it afterwards.
        cpu_rvalid = cpu_rd_q && !rst;
        dbg_rvalid = dbg_rd_q && !rst;
        cpu_rdata  = rst ? 8'd0 : (cpu_rd_q ? ram_q : cpu_rdata_q);
        dbg_rdata  = rst ? 8'd0 : (dbg_rd_q ? ram_q : dbg_rdata_q);
        lock_err   = lock_err_q;
    end

    always_comb begin
        if (!dbg_req || gnt_dbg) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q == STARVE_MAX) begin
            starve_cnt_d = STARVE_MAX;
        end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (!cpu_lock) begin
            lock_cnt_d = 4'd0;
        end else if (lock_cnt_q == LOCK_SAT) begin
            lock_cnt_d = LOCK_SAT;
        end else begin
            lock_cnt_d = lock_cnt_q + 4'd1;
        end

        lock_err_d  = lock_err_q || (cpu_lock && (lock_cnt_q == LOCK_SAT));
        cpu_rd_d    = gnt_cpu && !cpu_we;
        dbg_rd_d    = gnt_dbg && !dbg_we;
        cpu_rdata_d = cpu_rd_q ? ram_q : cpu_rdata_q;
        dbg_rdata_d = dbg_rd_q ? ram_q : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            lock_cnt_q   <= 4'd0;
            lock_err_q   <= 1'b0;
            cpu_rd_q     <= 1'b0;
            dbg_rd_q     <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            dbg_rdata_q  <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_err_q   <= lock_err_d;
            cpu_rd_q     <= cpu_rd_d;
            dbg_rd_q     <= dbg_rd_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, cpu_lock;
    logic [6:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dbg_req, dbg_we;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_gnt, dbg_rvalid;
    logic [7:0] dbg_rdata;
    logic [6:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_en;
    logic [7:0] ram_q;
    logic       lock_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q),
        .lock_err(lock_err)
    );

    logic [7:0] mem [0:127];
    always @(posedge clk) begin
        if (ram_en) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference model and read-data scoreboard, evaluated mid-cycle.
    logic [7:0] ref_mem [0:127];
    logic [7:0] cq[$];
    logic [7:0] dq[$];
    int   m_starve = 0;
    int   m_lock   = 0;
    bit   m_err    = 0;
    bit   m_cpu_rv = 0;
    bit   m_dbg_rv = 0;

    always @(negedge clk) begin
        bit lock_act, e_cpu, e_dbg, e_en;
        logic [7:0] exp_d;
        if (rst) begin
            n_cmp++;
            if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en} !== 5'b0) begin
                n_err++;
                $display("FAIL mon_reset_outputs: got %b expected 00000", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_en});
            end
            m_starve = 0; m_lock = 0; m_err = 0; m_cpu_rv = 0; m_dbg_rv = 0;
            cq.delete(); dq.delete();
        end else begin
            n_cmp++;
            if (cpu_rvalid !== m_cpu_rv) begin
                n_err++;
                $display("FAIL mon_cpu_rvalid: got %b expected %b", cpu_rvalid, m_cpu_rv);
            end
            if (m_cpu_rv) begin
                n_cmp++;
                if (cq.size() == 0) begin
                    n_err++;
                    $display("FAIL mon_cpu_queue: got empty expected entry");
                end else begin
                    exp_d = cq.pop_front();
                    if (cpu_rdata !== exp_d) begin
                        n_err++;
                        $display("FAIL mon_cpu_rdata: got %h expected %h", cpu_rdata, exp_d);
                    end
                end
            end
            n_cmp++;
            if (dbg_rvalid !== m_dbg_rv) begin
                n_err++;
                $display("FAIL mon_dbg_rvalid: got %b expected %b", dbg_rvalid, m_dbg_rv);
            end
            if (m_dbg_rv) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_err++;
                    $display("FAIL mon_dbg_queue: got empty expected entry");
                end else begin
                    exp_d = dq.pop_front();
                    if (dbg_rdata !== exp_d) begin
                        n_err++;
                        $display("FAIL mon_dbg_rdata: got %h expected %h", dbg_rdata, exp_d);
                    end
                end
            end
            n_cmp++;
            if (lock_err !== m_err) begin
                n_err++;
                $display("FAIL mon_lock_err: got %b expected %b", lock_err, m_err);
            end

            lock_act = cpu_lock && (m_lock < LOCK_MAX);
            e_cpu = 0; e_dbg = 0;
            if (lock_act) e_cpu = cpu_req;
            else if (dbg_req && m_starve == STARVE_LIMIT) e_dbg = 1;
            else if (cpu_req) e_cpu = 1;
            else if (dbg_req) e_dbg = 1;
            e_en = (e_cpu && cpu_we) || (e_dbg && dbg_we);

            n_cmp++;
            if ({cpu_gnt, dbg_gnt, ram_en} !== {e_cpu, e_dbg, e_en}) begin
                n_err++;
                $display("FAIL mon_grant: got cpu/dbg/en %b%b%b expected %b%b%b", cpu_gnt, dbg_gnt, ram_en, e_cpu, e_dbg, e_en);
            end
            if (e_cpu || e_dbg) begin
                n_cmp++;
                if (ram_addr !== (e_dbg ? dbg_addr : cpu_addr)) begin
                    n_err++;
                    $display("FAIL mon_ram_addr: got %h expected %h", ram_addr, e_dbg ? dbg_addr : cpu_addr);
                end
            end

            if (e_cpu) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else cq.push_back(ref_mem[cpu_addr]);
            end
            if (e_dbg) begin
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                else dq.push_back(ref_mem[dbg_addr]);
            end
            m_cpu_rv = e_cpu && !cpu_we;
            m_dbg_rv = e_dbg && !dbg_we;
            if (cpu_lock && m_lock == LOCK_MAX) m_err = 1;
            m_lock   = cpu_lock ? ((m_lock == LOCK_MAX) ? LOCK_MAX : m_lock + 1) : 0;
            m_starve = (!dbg_req || e_dbg) ? 0 : ((m_starve == STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h33; cpu_wdata = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_flags: got %b expected 00000", {cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid});
            end
            n_cmp++;
            if ({ram_addr, ram_data, cpu_rdata, dbg_rdata} !== 31'h0) begin
                n_err++;
                $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_data, cpu_rdata, dbg_rdata});
            end
            next_cycle();
        end
        rst = 0; cpu_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({lock_err, cpu_rdata, dbg_rdata} !== 17'h0) begin
            n_err++;
            $display("FAIL after_reset: got %h expected 0", {lock_err, cpu_rdata, dbg_rdata});
        end
        next_cycle();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h20; cpu_wdata = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if ({cpu_gnt, ram_en, dbg_gnt} !== 3'b110) begin
            n_err++;
            $display("FAIL cpu_write_gnt: got %b expected 110", {cpu_gnt, ram_en, dbg_gnt});
        end
        next_cycle();
        cpu_we = 0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_gnt, ram_en, cpu_rvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL cpu_read_gnt: got %b expected 100", {cpu_gnt, ram_en, cpu_rvalid});
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
            n_err++;
            $display("FAIL cpu_read_data: got %b/%h expected 1/5a", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A || dbg_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_rdata_hold: got %b/%h/%b expected 0/5a/0", cpu_rvalid, cpu_rdata, dbg_gnt);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h20;
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'h20;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dbg_gnt !== ((i % 5) == 4) || cpu_gnt !== ((i % 5) != 4)) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got cpu/dbg %b%b expected %b%b", i, cpu_gnt, dbg_gnt, (i % 5) != 4, (i % 5) == 4);
            end
            next_cycle();
        end
        cpu_req = 0; dbg_req = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lock();
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h10; cpu_wdata = 8'h03;
        next_cycle();
        cpu_lock = 1; cpu_we = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'h10;
        @(negedge clk);
        n_cmp++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_read_gnt: got %b expected 10", {cpu_gnt, dbg_gnt});
        end
        next_cycle();
        cpu_we = 1; cpu_wdata = 8'h04;
        @(negedge clk);
        n_cmp++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid} !== 3'b101 || cpu_rdata !== 8'h03) begin
            n_err++;
            $display("FAIL lock_rmw: got %b/%h expected 101/03", {cpu_gnt, dbg_gnt, cpu_rvalid}, cpu_rdata);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_gnt, dbg_gnt} !== 2'b00) begin
            n_err++;
            $display("FAIL lock_idle_hold: got %b expected 00", {cpu_gnt, dbg_gnt});
        end
        next_cycle();
        cpu_lock = 0;
        @(negedge clk);
        n_cmp++;
        if (dbg_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL lock_release_dbg: got %b expected 1", dbg_gnt);
        end
        next_cycle();
        dbg_req = 0;
        @(negedge clk);
        n_cmp++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'h04) begin
            n_err++;
            $display("FAIL lock_dbg_data: got %b/%h expected 1/04", dbg_rvalid, dbg_rdata);
        end
        next_cycle();
    endtask

    task automatic test_lock_overrun();
        cpu_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 7'h20;
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dbg_gnt !== (i == 9) || lock_err !== (i >= 10)) begin
                n_err++;
                $display("FAIL overrun_cycle%0d: got dbg/err %b%b expected %b%b", i, dbg_gnt, lock_err, i == 9, i >= 10);
            end
            next_cycle();
        end
        cpu_lock = 0; cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (lock_err !== 1'b1) begin
                n_err++;
                $display("FAIL lock_err_sticky: got %b expected 1", lock_err);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'h10;
        @(negedge clk);
        n_cmp++;
        if (dbg_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt: got %b expected 1", dbg_gnt);
        end
        next_cycle();
        rst = 1; dbg_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_rvalid, dbg_gnt, cpu_gnt} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_outputs: got %b expected 000", {dbg_rvalid, dbg_gnt, cpu_gnt});
        end
        next_cycle();
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_rvalid, lock_err} !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_after: got %b expected 00", {dbg_rvalid, lock_err});
        end
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h20; dbg_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dbg_gnt !== (i == 4)) begin
                n_err++;
                $display("FAIL midrst_starve%0d: got %b expected %b", i, dbg_gnt, i == 4);
            end
            next_cycle();
        end
        cpu_req = 0; dbg_req = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 1;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 7'(k);
            cpu_wdata = 8'hC0 + 8'(k);
            next_cycle();
        end
        cpu_req = 0;
        dbg_we = 0;
        for (int k = 0; k < 5; k++) begin
            dbg_req = (k < 4);
            dbg_addr = 7'(k);
            @(negedge clk);
            n_cmp++;
            if (dbg_gnt !== (k < 4) || dbg_rvalid !== (k >= 1)) begin
                n_err++;
                $display("FAIL b2b_flags%0d: got gnt/rv %b%b expected %b%b", k, dbg_gnt, dbg_rvalid, k < 4, k >= 1);
            end
            if (k >= 1) begin
                n_cmp++;
                if (dbg_rdata !== 8'hC0 + 8'(k - 1)) begin
                    n_err++;
                    $display("FAIL b2b_data%0d: got %h expected %h", k, dbg_rdata, 8'hC0 + 8'(k - 1));
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'hC3) begin
            n_err++;
            $display("FAIL b2b_hold: got %b/%h expected 0/c3", dbg_rvalid, dbg_rdata);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_lock = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        test_reset();
        test_cpu_only();
        test_starvation();
        test_lock();
        test_lock_overrun();
        test_reset_mid_read();
        test_back_to_back();
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (cq.size() != 0 || dq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", cq.size(), dq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
